// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned WAIT_MAX_DEF     = 15;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Address mux select codes
  localparam logic SEL_IF  = 1'b0;
  localparam logic SEL_MEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_ACC  = 2'd1,
    ST_MEM_ACC = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the pipeline stages, the arbiter and the shared memory port.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              port_ready;
  logic [DATA_W-1:0] port_rdata;

  logic              port_req;
  logic              port_we;
  logic              addr_sel;
  logic [DATA_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;
  logic              if_done;
  logic              mem_done;
  logic [DATA_W-1:0] rdata;
  logic              timeout;
  logic              stall;

  // Environment side: pipeline stages plus memory
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ready, port_rdata,
    input  port_req, port_we, addr_sel, port_addr, port_wdata, if_done, mem_done, rdata,
           timeout, stall
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ready, port_rdata,
    output port_req, port_we, addr_sel, port_addr, port_wdata, if_done, mem_done, rdata,
           timeout, stall
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 2:1 select between fetch and data inputs of the shared port.
module mem_port_arbiter_mux
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = (sel_i == SEL_MEM) ? b_i : a_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch and data stages, with starvation
// protection for fetch and a bounded wait for port_ready.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_MAX     = WAIT_MAX_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam int unsigned WAIT_CW  = WAIT_W + 1;
  localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q,      state_d;
  logic [STARVE_W-1:0] starve_q,     starve_d;
  logic [WAIT_W-1:0]   wait_q,       wait_d;
  logic                addr_sel_q,   addr_sel_d;
  logic                port_req_q,   port_req_d;
  logic                port_we_q,    port_we_d;
  logic [DATA_W-1:0]   port_wdata_q, port_wdata_d;
  logic [DATA_W-1:0]   rdata_q,      rdata_d;
  logic                if_done_q,    if_done_d;
  logic                mem_done_q,   mem_done_d;
  logic                timeout_q,    timeout_d;

  logic               starve_hit;
  logic [WAIT_CW-1:0] wait_inc;
  logic               wait_expire;

  assign starve_hit  = bus.if_req && (starve_q == STARVE_W'(STARVE_LIMIT));
  assign wait_inc    = {1'b0, wait_q} + WAIT_CW'(1);
  assign wait_expire = (wait_inc >= WAIT_CW'(WAIT_MAX));

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    wait_d     = wait_q;
    addr_sel_d = addr_sel_q;
    rdata_d    = rdata_q;
    if_done_d  = 1'b0;
    mem_done_d = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_req && !starve_hit) begin
          state_d    = ST_MEM_ACC;
          addr_sel_d = SEL_MEM;
          wait_d     = '0;
          if (bus.if_req) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else if (bus.if_req) begin
          state_d    = ST_IF_ACC;
          addr_sel_d = SEL_IF;
          wait_d     = '0;
          starve_d   = '0;
        end
      end
      ST_IF_ACC, ST_MEM_ACC: begin
        // A ready arriving on the last allowed cycle still completes normally
        if (bus.port_ready) begin
          state_d = ST_DONE;
          rdata_d = bus.port_rdata;
          if (state_q == ST_IF_ACC) begin
            if_done_d = 1'b1;
          end else begin
            mem_done_d = 1'b1;
          end
        end else begin
          wait_d = WAIT_W'(wait_inc);
          if (wait_expire) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    port_req_d   = (state_d == ST_IF_ACC) || (state_d == ST_MEM_ACC);
    port_we_d    = (state_d == ST_MEM_ACC) && bus.mem_we;
    port_wdata_d = port_we_d ? bus.mem_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      wait_q       <= '0;
      addr_sel_q   <= SEL_IF;
      port_req_q   <= 1'b0;
      port_we_q    <= 1'b0;
      port_wdata_q <= '0;
      rdata_q      <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      addr_sel_q   <= addr_sel_d;
      port_req_q   <= port_req_d;
      port_we_q    <= port_we_d;
      port_wdata_q <= port_wdata_d;
      rdata_q      <= rdata_d;
      if_done_q    <= if_done_d;
      mem_done_q   <= mem_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.port_req   = port_req_q;
  assign bus.port_we    = port_we_q;
  assign bus.addr_sel   = addr_sel_q;
  assign bus.port_wdata = port_wdata_q;
  assign bus.rdata      = rdata_q;
  assign bus.if_done    = if_done_q;
  assign bus.mem_done   = mem_done_q;
  assign bus.timeout    = timeout_q;
  assign bus.stall      = (bus.if_req | bus.mem_req) & ~(if_done_q | mem_done_q);

  mem_port_arbiter_mux #(.W(DATA_W)) u_addr_mux (
    .sel_i (addr_sel_q),
    .a_i   (bus.if_addr),
    .b_i   (bus.mem_addr),
    .y_o   (bus.port_addr)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written
// arbitration, starvation and reset sequences, completions checked via a scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int WMAX = 15;
  localparam int SLIM = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] last_rdata = 32'h0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.WAIT_MAX(WMAX), .STARVE_LIMIT(SLIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  // kind: 0 = if_done, 1 = mem_done, 2 = timeout
  typedef struct {
    int          kind;
    logic [31:0] rdata;
    int          at_cyc;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ready_wait;  // ACC cycles without ready before ready; -1 = never
    logic [31:0] prdata;
    logic        exp_sel;
    logic        exp_we;
    logic [31:0] exp_wdata;
    int          exp_kind;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] rd, input int at);
    exp_t e;
    if (kind != 2) last_rdata = rd;
    e.kind   = kind;
    e.rdata  = last_rdata;
    e.at_cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic collect();
    int          budget;
    exp_t        e;
    logic [2:0]  act;
    logic [2:0]  want;
    logic        exp_stall;
    budget = 40;
    while (!(bus.if_done || bus.mem_done || bus.timeout) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL completion_wait @cycle %0d: no done/timeout within 40 cycles", cyc);
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end else if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_pulse @cycle %0d: completion with empty scoreboard", cyc);
    end else begin
      e         = exp_q.pop_front();
      act       = {bus.timeout, bus.mem_done, bus.if_done};
      want      = 3'(1 << e.kind);
      exp_stall = (bus.if_req | bus.mem_req) & (e.kind == 2);
      chk("done_kind", 32'(act), 32'(want));
      chk("rdata", bus.rdata, e.rdata);
      chk("done_cycle", 32'(cyc), 32'(e.at_cyc));
      chk("stall_at_done", 32'(bus.stall), 32'(exp_stall));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_port_req"},   32'(bus.port_req), 32'd0);
    chk({tag, "_port_we"},    32'(bus.port_we),  32'd0);
    chk({tag, "_addr_sel"},   32'(bus.addr_sel), 32'd0);
    chk({tag, "_port_wdata"}, bus.port_wdata,    32'd0);
    chk({tag, "_rdata"},      bus.rdata,         32'd0);
    chk({tag, "_if_done"},    32'(bus.if_done),  32'd0);
    chk({tag, "_mem_done"},   32'(bus.mem_done), 32'd0);
    chk({tag, "_timeout"},    32'(bus.timeout),  32'd0);
  endtask

  // Single access from IDLE; entered and left on a negedge with the arbiter idle
  task automatic run_vec(input vec_t v);
    int c0;
    int w_eff;
    bus.if_req     = ~v.is_mem;
    bus.if_addr    = v.is_mem ? 32'h0 : v.addr;
    bus.mem_req    = v.is_mem;
    bus.mem_we     = v.we;
    bus.mem_addr   = v.is_mem ? v.addr : 32'h0;
    bus.mem_wdata  = v.wdata;
    bus.port_ready = 1'b0;
    bus.port_rdata = v.prdata;
    c0    = cyc;
    w_eff = (v.ready_wait < 0 || v.ready_wait > WMAX - 1) ? WMAX - 1 : v.ready_wait;
    push_exp(v.exp_kind, v.prdata, c0 + 2 + w_eff);
    @(negedge clk);
    chk("grant_port_req", 32'(bus.port_req), 32'd1);
    chk("grant_addr_sel", 32'(bus.addr_sel), 32'(v.exp_sel));
    chk("grant_port_we", 32'(bus.port_we), 32'(v.exp_we));
    chk("grant_port_wdata", bus.port_wdata, v.exp_wdata);
    chk("grant_port_addr", bus.port_addr, v.addr);
    chk("grant_stall", 32'(bus.stall), 32'd1);
    if (v.ready_wait >= 0) begin
      repeat (v.ready_wait) @(negedge clk);
      bus.port_ready = 1'b1;
    end
    collect();
    bus.port_ready = 1'b0;
    bus.if_req     = 1'b0;
    bus.mem_req    = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", 32'({bus.timeout, bus.mem_done, bus.if_done}), 32'd0);
    chk("idle_port_req", 32'(bus.port_req), 32'd0);
    chk("addr_sel_hold", 32'(bus.addr_sel), 32'(v.exp_sel));
  endtask

  initial begin
    int   c0;
    int   b;
    logic exp_sel;
    logic [31:0] rd;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF,  0, 32'h8C01_0004, 1'b0, 1'b0, 32'h0,          0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h1234_5678,  2, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,          1};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF,  1, 32'h1111_1111, 1'b1, 1'b1, 32'hDEAD_BEEF,  1};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, -1, 32'h9999_9999, 1'b1, 1'b1, 32'h0BAD_F00D,  2};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         14, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0,          0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0084, 32'h0,         -1, 32'h6666_6666, 1'b0, 1'b0, 32'h0,          2};

    rst            = 1'b1;
    bus.if_req     = 1'b0;
    bus.if_addr    = 32'h0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'h0;
    bus.port_ready = 1'b0;
    bus.port_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous requests: data first, fetch three cycles later
    bus.mem_req    = 1'b1;
    bus.mem_we     = 1'b1;
    bus.mem_addr   = 32'h0000_0100;
    bus.mem_wdata  = 32'hDEAD_BEEF;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h0000_0040;
    bus.port_rdata = 32'hAAAA_0001;
    c0 = cyc;
    push_exp(1, 32'hAAAA_0001, c0 + 2);
    push_exp(0, 32'hAAAA_0002, c0 + 5);
    @(negedge clk);
    chk("both_mem_sel", 32'(bus.addr_sel), 32'd1);
    chk("both_mem_we", 32'(bus.port_we), 32'd1);
    chk("both_mem_wdata", bus.port_wdata, 32'hDEAD_BEEF);
    chk("both_mem_addr", bus.port_addr, 32'h0000_0100);
    bus.port_ready = 1'b1;
    collect();
    bus.mem_req    = 1'b0;
    bus.port_ready = 1'b0;
    bus.port_rdata = 32'hAAAA_0002;
    @(negedge clk);
    chk("both_gap_stall", 32'(bus.stall), 32'd1);
    chk("both_gap_port_req", 32'(bus.port_req), 32'd0);
    @(negedge clk);
    chk("both_if_sel", 32'(bus.addr_sel), 32'd0);
    chk("both_if_we", 32'(bus.port_we), 32'd0);
    chk("both_if_wdata", bus.port_wdata, 32'd0);
    chk("both_if_addr", bus.port_addr, 32'h0000_0040);
    bus.port_ready = 1'b1;
    collect();
    bus.if_req     = 1'b0;
    bus.port_ready = 1'b0;
    @(negedge clk);

    // Starvation: four data grants, then fetch, then data again
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0300;
    bus.mem_wdata = 32'h1357_9BDF;
    bus.if_addr   = 32'h0000_0044;
    bus.if_req    = 1'b1;
    bus.mem_req   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_sel = (i == 4) ? 1'b0 : 1'b1;
      b = 0;
      do begin
        @(negedge clk);
        b++;
      end while (!bus.port_req && b < 8);
      if (!bus.port_req) begin
        n_cmp++;
        n_err++;
        $display("FAIL starve_grant_wait @cycle %0d: no grant for access %0d", cyc, i);
      end else begin
        chk("starve_sel", 32'(bus.addr_sel), 32'(exp_sel));
        chk("starve_port_we", 32'(bus.port_we), 32'(exp_sel));
        chk("starve_port_addr", bus.port_addr, exp_sel ? 32'h0000_0300 : 32'h0000_0044);
        rd = 32'hB000_0000 + 32'(i);
        bus.port_rdata = rd;
        bus.port_ready = 1'b1;
        push_exp(exp_sel ? 1 : 0, rd, cyc + 1);
        collect();
        bus.port_ready = 1'b0;
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second data-access cycle
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0400;
    bus.mem_wdata = 32'h2468_1357;
    @(negedge clk);
    chk("rst_seq_grant", 32'(bus.port_req), 32'd1);
    @(negedge clk);
    rst            = 1'b1;
    bus.port_ready = 1'b1;
    bus.port_rdata = 32'h7777_7777;
    bus.mem_req    = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst        = 1'b0;
    last_rdata = 32'h0;
    // port_ready while idle must be ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready_pulses", 32'({bus.timeout, bus.mem_done, bus.if_done}), 32'd0);
      chk("idle_ready_rdata", bus.rdata, 32'd0);
      chk("idle_ready_port_req", 32'(bus.port_req), 32'd0);
    end
    bus.port_ready = 1'b0;
    @(negedge clk);

    run_vec(vecs[0]);
    run_vec(vecs[5]);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
